std_pending_drain: RTL and testbench

//  Consumer side of a bit-enabled pending-event register. Producers set

---
 rtl/std_pending_drain.sv | 92 +++++++++
 tb/tb_std_pending_drain.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/std_pending_drain.sv
// Round-robin drain of a bit-enabled pending-event register.
// Each drained bit leaves as an index on a valid/ready output.
module std_pending_drain #(
   parameter int WIDTH     = 8,
   parameter int IDX_WIDTH = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     set_en,
   input  logic                 flush,
   output logic [WIDTH-1:0]     pend,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [IDX_WIDTH-1:0] out_idx
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [IDX_WIDTH-1:0] rr_ptr;
   logic [IDX_WIDTH-1:0] rr_nxt;
   logic [IDX_WIDTH-1:0] sel;
   logic [WIDTH-1:0]     ge_mask;
   logic [WIDTH-1:0]     pend_hi;
   logic [WIDTH-1:0]     clr;
   logic                 any_pend;
   logic                 any_hi;
   logic                 fire;
   logic                 load;

   function automatic logic [IDX_WIDTH-1:0] lowest_set(input logic [WIDTH-1:0] v);
      lowest_set = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (v[i]) lowest_set = IDX_WIDTH'(i);
      end
   endfunction

   // Round-robin: prefer bits at or above rr_ptr, otherwise wrap to the lowest set bit.
   always_comb begin
      ge_mask = '0;
      for (int i = 0; i < WIDTH; i++) begin
         ge_mask[i] = (i >= int'(rr_ptr));
      end
   end

   assign pend_hi  = pend & ge_mask;
   assign any_hi   = |pend_hi;
   assign any_pend = |pend;
   assign sel      = any_hi ? lowest_set(pend_hi) : lowest_set(pend);

   assign out_valid = (state == FULL);
   assign fire      = out_valid & out_ready;
   assign load      = (~out_valid | fire) & any_pend & ~flush;

   assign rr_nxt = (sel == IDX_WIDTH'(WIDTH - 1)) ? '0 : sel + IDX_WIDTH'(1);
   assign clr    = load ? (WIDTH'(1) << sel) : '0;

   always_comb begin
      state_nxt = state;
      if (flush)     state_nxt = EMPTY;
      else if (load) state_nxt = FULL;
      else if (fire) state_nxt = EMPTY;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= EMPTY;
      else       state <= state_nxt;
   end

   // A set_en on the bit being cleared this edge survives: it is a fresh event.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend    <= '0;
         rr_ptr  <= '0;
         out_idx <= '0;
      end else if (flush) begin
         pend    <= '0;
         rr_ptr  <= '0;
      end else begin
         pend <= (pend & ~clr) | set_en;
         if (load) begin
            out_idx <= sel;
            rr_ptr  <= rr_nxt;
         end
      end
   end

endmodule

// File: tb/tb_std_pending_drain.sv
// Directed bench for std_pending_drain: an event-level model is checked every
// cycle, and hand-computed literals pin both the DUT and the model.
module tb_std_pending_drain;
   localparam int W  = 8;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  set_en;
   logic          flush;
   logic [W-1:0]  pend;
   logic          out_valid;
   logic          out_ready;
   logic [IW-1:0] out_idx;

   int n_checks = 0;
   int n_fail   = 0;

   std_pending_drain #(.WIDTH(W), .IDX_WIDTH(IW)) dut (
      .clk       (clk),
      .reset     (reset),
      .set_en    (set_en),
      .flush     (flush),
      .pend      (pend),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx)
   );

   always #5 clk = ~clk;

   // Event-level model: a set of pending sources, a "next source to serve"
   // pointer, and a one-entry output slot.
   logic [W-1:0] m_pend;
   int           m_next;
   bit           m_v;
   int           m_idx;
   bit           m_live = 0;
   int           accepted[$];

   always @(posedge clk) begin
      bit           take;
      int           pick;
      logic [W-1:0] np;
      if (reset) begin
         m_pend = '0; m_next = 0; m_v = 0; m_idx = 0; m_live = 1;
      end else if (m_live) begin
         if (m_v && out_ready && !flush) accepted.push_back(m_idx);
         take = !m_v || out_ready;
         pick = -1;
         for (int k = 0; k < W; k++) begin
            int j;
            j = (m_next + k) % W;
            if (pick < 0 && m_pend[j]) pick = j;
         end
         if (flush) begin
            m_pend = '0; m_next = 0; m_v = 0;
         end else begin
            np = m_pend;
            if (take && pick >= 0) begin
               np[pick] = 1'b0;
               m_idx    = pick;
               m_v      = 1;
               m_next   = (pick + 1) % W;
            end else if (take) begin
               m_v = 0;
            end
            m_pend = np | set_en;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_live) begin
         check("model_pend", int'(pend), int'(m_pend));
         check("model_valid", int'(out_valid), int'(m_v));
         if (m_v) check("model_idx", int'(out_idx), m_idx);
      end
   end

   task automatic step(input logic [W-1:0] s, input logic r, input logic f);
      set_en = s; out_ready = r; flush = f;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; set_en = 8'hFF; out_ready = 1'b0; flush = 1'b0;
      // 1. reset dominates set_en
      @(posedge clk); #1;
      step(8'hFF, 1'b0, 1'b0);
      check("reset_pend", int'(pend), 0);
      check("reset_valid", int'(out_valid), 0);
      check("reset_idx", int'(out_idx), 0);
      reset = 1'b0;
      step(8'h00, 1'b0, 1'b0);
      check("post_reset_pend", int'(pend), 0);
      check("post_reset_valid", int'(out_valid), 0);

      // 2. single event, two-cycle latency
      step(8'h10, 1'b1, 1'b0);
      check("single_pend", int'(pend), 8'h10);
      check("single_valid_early", int'(out_valid), 0);
      step(8'h00, 1'b1, 1'b0);
      check("single_valid", int'(out_valid), 1);
      check("single_idx", int'(out_idx), 4);
      check("single_pend_clr", int'(pend), 0);
      step(8'h00, 1'b1, 1'b0);
      check("single_done", int'(out_valid), 0);

      // 3. round-robin at full throughput, starting from pointer 0
      step(8'h00, 1'b0, 1'b1);
      step(8'h85, 1'b1, 1'b0);
      check("rr_pend", int'(pend), 8'h85);
      step(8'h00, 1'b1, 1'b0);
      check("rr_idx0", int'(out_idx), 0);
      check("rr_pend0", int'(pend), 8'h84);
      step(8'h00, 1'b1, 1'b0);
      check("rr_idx2", int'(out_idx), 2);
      step(8'h00, 1'b1, 1'b0);
      check("rr_idx7", int'(out_idx), 7);
      check("rr_valid7", int'(out_valid), 1);
      step(8'h00, 1'b1, 1'b0);
      check("rr_empty", int'(out_valid), 0);
      step(8'h05, 1'b1, 1'b0);
      step(8'h00, 1'b1, 1'b0);
      check("wrap_idx0", int'(out_idx), 0);
      step(8'h00, 1'b1, 1'b0);
      check("wrap_idx2", int'(out_idx), 2);
      step(8'h00, 1'b1, 1'b0);
      check("wrap_empty", int'(out_valid), 0);
      check("model_pin_pend", int'(m_pend), 0);

      // 4. backpressure holds out_idx; set on an already-pending bit coalesces
      step(8'h06, 1'b0, 1'b0);
      step(8'h00, 1'b0, 1'b0);
      for (int c = 0; c < 5; c++) begin
         step((c == 2) ? 8'h04 : 8'h00, 1'b0, 1'b0);
         check("bp_idx", int'(out_idx), 1);
         check("bp_valid", int'(out_valid), 1);
         check("bp_pend", int'(pend), 8'h04);
      end
      step(8'h00, 1'b1, 1'b0);
      check("bp_next_idx", int'(out_idx), 2);
      check("bp_next_valid", int'(out_valid), 1);
      step(8'h00, 1'b1, 1'b0);
      check("bp_done", int'(out_valid), 0);

      // 5. set_en on the bit being loaded re-arms it
      step(8'h08, 1'b1, 1'b0);
      step(8'h08, 1'b1, 1'b0);
      check("rearm_idx", int'(out_idx), 3);
      check("rearm_pend", int'(pend), 8'h08);
      step(8'h00, 1'b1, 1'b0);
      check("rearm_again_idx", int'(out_idx), 3);
      check("rearm_again_valid", int'(out_valid), 1);
      check("rearm_pend_clr", int'(pend), 0);
      step(8'h00, 1'b1, 1'b0);

      // 6. flush mid-drain drops everything, including same-cycle set_en
      step(8'hF0, 1'b0, 1'b0);
      step(8'h10, 1'b0, 1'b0);
      check("pre_flush_pend", int'(pend), 8'hF0);
      check("pre_flush_valid", int'(out_valid), 1);
      step(8'h01, 1'b0, 1'b1);
      check("flush_pend", int'(pend), 0);
      check("flush_valid", int'(out_valid), 0);
      accepted.delete();
      step(8'h00, 1'b1, 1'b0);
      step(8'h00, 1'b1, 1'b0);
      check("flush_quiet_valid", int'(out_valid), 0);
      check("flush_no_events", accepted.size(), 0);
      step(8'h22, 1'b1, 1'b0);
      step(8'h00, 1'b1, 1'b0);
      check("flush_rr_zero", int'(out_idx), 1);
      step(8'h00, 1'b1, 1'b0);
      check("flush_rr_next", int'(out_idx), 5);
      step(8'h00, 1'b1, 1'b0);
      check("final_empty", int'(out_valid), 0);
      check("model_pin_accepted", accepted.size(), 2);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
